rll_tx_scheduler: RTL

Transmit-side sequencer for the RLL(2,7) link. Accepts a byte stream over a valid/ready handshake and parses it MSB-first into variable-length data words (2, 3 or 4 bits). It emits the matching 4-, 6- or 8-bit code words serially, one bit per accepted output beat. It sits in front of the line driver and is the counterpart of the RLL receiver. Its word-length code uses the receiver's `valid` encoding: 01 = 8-bit, 10 = 6-bit, 11 = 4-bit.

---
 rtl/rll_tx_scheduler_pkg.sv | 31 +++
 rtl/rll_tx_scheduler_lookup.sv | 24 ++
 rtl/rll_tx_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rll_tx_scheduler_pkg.sv
// rll_pkg: shared length codes, code-word constants, FSM states and saturating add for the RLL(2,7) transmitter
package rll_pkg;

    typedef enum logic [1:0] {
        RLL_NONE = 2'b00,
        RLL_LEN8 = 2'b01,
        RLL_LEN6 = 2'b10,
        RLL_LEN4 = 2'b11
    } rll_len_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_FLUSH
    } rll_state_t;

    localparam logic [7:0] CODE_10   = 8'b0100_0000;
    localparam logic [7:0] CODE_11   = 8'b1000_0000;
    localparam logic [7:0] CODE_000  = 8'b0001_0000;
    localparam logic [7:0] CODE_010  = 8'b1001_0000;
    localparam logic [7:0] CODE_011  = 8'b0010_0000;
    localparam logic [7:0] CODE_0010 = 8'b0010_0100;
    localparam logic [7:0] CODE_0011 = 8'b0000_1000;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/rll_tx_scheduler_lookup.sv
// rll_code_lookup: maps the top four buffered data bits to an RLL(2,7) code word, gated by fill count
module rll_code_lookup
    import rll_pkg::*;
(
    input  logic [3:0] bits,
    input  logic [4:0] cnt,
    output logic       hit,
    output logic [2:0] dlen,
    output logic [7:0] code,
    output rll_len_t   len
);

    // Prefix decode: a leading 1 is a 2-bit word, 01x and 000 are 3-bit, 001x is 4-bit
    always_comb begin
        dlen = bits[3] ? 3'd2 : (bits[2] || !bits[1]) ? 3'd3 : 3'd4;
        code = bits[3] ? (bits[2] ? CODE_11 : CODE_10)
             : bits[2] ? (bits[1] ? CODE_011 : CODE_010)
             : bits[1] ? (bits[0] ? CODE_0011 : CODE_0010)
             : CODE_000;
        len  = (dlen == 3'd2) ? RLL_LEN4 : (dlen == 3'd3) ? RLL_LEN6 : RLL_LEN8;
        hit  = {2'b00, dlen} <= cnt;
    end

endmodule

// File: rtl/rll_tx_scheduler.sv
// rll_tx_scheduler: byte-in, serial RLL(2,7) code-bit-out sequencer; RLL_TX_STATS_EN adds word/pad counters
module rll_tx_scheduler
    import rll_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       flush_i,
    output logic       out_bit_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       word_start_o,
    output logic [1:0] out_len_o,
    output logic       flush_done_o,
    output logic       busy_o
`ifdef RLL_TX_STATS_EN
    ,
    output logic [15:0] stat_w8_o,
    output logic [15:0] stat_w6_o,
    output logic [15:0] stat_w4_o,
    output logic [15:0] stat_pad_o
`endif
);

    logic [11:0] buf_q, buf_app, buf_base, buf_d;
    logic [4:0]  cnt_q, cnt_base, cnt_d, lk_cnt;
    logic [7:0]  code_q, lk_code;
    logic [3:0]  rem_q, lk_bits;
    logic [2:0]  lk_dlen;
    logic        lk_hit, accept, idle_acc, shake, last, load, start_q, flush_pend_q;
    rll_len_t    len_q, lk_len;
    rll_state_t  state_q, state_d;

    rll_code_lookup u_lookup (
        .bits (lk_bits),
        .cnt  (lk_cnt),
        .hit  (lk_hit),
        .dlen (lk_dlen),
        .code (lk_code),
        .len  (lk_len)
    );

    assign ready_o      = (cnt_q <= 5'd4) && !flush_pend_q;
    assign out_valid_o  = state_q == ST_SEND;
    assign out_bit_o    = code_q[7];
    assign word_start_o = start_q;
    assign out_len_o    = len_q;
    assign busy_o       = (cnt_q != 5'd0) || (state_q != ST_IDLE) || flush_pend_q;

    // From IDLE the incoming byte is parsed at once so its first code bit appears the next cycle;
    // in SEND the pre-accept buffer decides the hit. FLUSH forces a hit on the zero-padded tail.
    always_comb begin
        accept       = valid_i && ready_o;
        buf_app      = buf_q | ({data_i, 4'b0000} >> cnt_q);
        idle_acc     = (state_q == ST_IDLE) && accept;
        lk_bits      = idle_acc ? buf_app[11:8] : buf_q[11:8];
        lk_cnt       = (state_q == ST_FLUSH) ? 5'd4 : cnt_q + (idle_acc ? 5'd8 : 5'd0);
        shake        = (state_q == ST_SEND) && out_ready_i;
        last         = shake && (rem_q == 4'd1);
        load         = (state_q == ST_FLUSH) || (lk_hit && ((state_q == ST_IDLE) || last));
        buf_base     = accept ? buf_app : buf_q;
        cnt_base     = cnt_q + (accept ? 5'd8 : 5'd0);
        buf_d        = (state_q == ST_FLUSH) ? 12'd0 : load ? buf_base << lk_dlen : buf_base;
        cnt_d        = (state_q == ST_FLUSH) ? 5'd0 : load ? cnt_base - {2'b00, lk_dlen} : cnt_base;
        flush_done_o = (state_q == ST_IDLE) && flush_pend_q && (cnt_q == 5'd0) && !lk_hit;
        state_d      = load ? ST_SEND
                     : ((state_q == ST_IDLE) && flush_pend_q && (cnt_q != 5'd0)) ? ST_FLUSH
                     : last ? ST_IDLE : state_q;
    end

    // FSM, bit buffer and flush-pending registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_done_o ? 1'b0 : (flush_i || flush_pend_q);
        end
    end

    // Code word shifter: load a new word or shift out one bit per handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_q  <= '0;
            rem_q   <= '0;
            len_q   <= RLL_NONE;
            start_q <= 1'b0;
        end else if (load) begin
            code_q  <= lk_code;
            rem_q   <= {lk_dlen, 1'b0};
            len_q   <= lk_len;
            start_q <= 1'b1;
        end else if (shake) begin
            code_q  <= code_q << 1;
            rem_q   <= rem_q - 4'd1;
            len_q   <= last ? RLL_NONE : len_q;
            start_q <= 1'b0;
        end
    end

`ifdef RLL_TX_STATS_EN
    // Saturating counters of loaded words per length and of zero bits padded by flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_w8_o  <= '0;
            stat_w6_o  <= '0;
            stat_w4_o  <= '0;
            stat_pad_o <= '0;
        end else begin
            stat_w8_o  <= (load && lk_len == RLL_LEN8) ? sat_add(stat_w8_o, 5'd1) : stat_w8_o;
            stat_w6_o  <= (load && lk_len == RLL_LEN6) ? sat_add(stat_w6_o, 5'd1) : stat_w6_o;
            stat_w4_o  <= (load && lk_len == RLL_LEN4) ? sat_add(stat_w4_o, 5'd1) : stat_w4_o;
            stat_pad_o <= (state_q == ST_FLUSH) ? sat_add(stat_pad_o, {2'b00, lk_dlen} - cnt_q) : stat_pad_o;
        end
    end
`endif

endmodule
